// File: rtl/frq_div_ring.sv
// Programmable mclk divider with tick strobe and one-hot/Johnson ring.
// Divisor loads are deferred to the next terminal edge while counting.
module frq_div_ring #(
    parameter int CNT_W   = 16,
    parameter int RING_N  = 4,
    parameter int JOHNSON = 0,
    parameter int DEF_DIV = 10
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  div,
    input  logic              div_ld,
    input  logic              dir,
    output logic              clk,
    output logic              tick,
    output logic [RING_N-1:0] ring,
    output logic              wrap
);

    localparam logic [CNT_W-1:0]  DEF_D = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0]  MIN_D = CNT_W'(2);
    localparam logic [RING_N-1:0] ONE   = RING_N'(1);
    localparam logic [RING_N-1:0] RST_RING =
        (JOHNSON != 0) ? '0 : ONE;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_d;
    logic [CNT_W-1:0]  r_pend;
    logic              r_pend_v;
    logic              r_clk;
    logic              r_tick;
    logic              r_wrap;
    logic [RING_N-1:0] r_ring;

    logic [CNT_W:0]    w_dm1;
    logic [CNT_W:0]    w_half;
    logic [CNT_W:0]    w_inc;
    logic              w_term;
    logic [CNT_W-1:0]  w_div;
    logic              w_onehot;
    logic [RING_N-1:0] w_ring_nx;

    // One extra bit keeps D-1 and (D+1)>>1 exact at the top of the range.
    assign w_dm1  = {1'b0, r_d} - 1'b1;
    assign w_half = ({1'b0, r_d} + 1'b1) >> 1;
    assign w_inc  = {1'b0, r_cnt} + 1'b1;
    assign w_term = en && ({1'b0, r_cnt} == w_dm1);
    assign w_div  = (div < MIN_D) ? MIN_D : div;

    assign w_onehot = (r_ring != '0) &&
                      ((r_ring & (r_ring - ONE)) == '0);

    // Next ring pattern for the coming advance.
    always_comb begin
        w_ring_nx = r_ring;
        if (JOHNSON != 0) begin
            if (dir)
                w_ring_nx = {r_ring[RING_N-2:0], ~r_ring[RING_N-1]};
            else
                w_ring_nx = {~r_ring[0], r_ring[RING_N-1:1]};
        end else if (!w_onehot) begin
            w_ring_nx = ONE;
        end else if (dir) begin
            w_ring_nx = {r_ring[RING_N-2:0], r_ring[RING_N-1]};
        end else begin
            w_ring_nx = {r_ring[0], r_ring[RING_N-1:1]};
        end
    end

    // Period counter, active divisor and pending divisor.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_d      <= DEF_D;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (en) begin
            if (w_term) begin
                r_cnt    <= '0;
                r_pend_v <= 1'b0;
                if (div_ld)
                    r_d <= w_div;
                else if (r_pend_v)
                    r_d <= r_pend;
            end else begin
                r_cnt <= w_inc[CNT_W-1:0];
                if (div_ld) begin
                    r_pend   <= w_div;
                    r_pend_v <= 1'b1;
                end
            end
        end else if (div_ld) begin
            r_d      <= w_div;
            r_cnt    <= '0;
            r_pend_v <= 1'b0;
        end
    end

    // Divided clock: rises on the terminal edge, falls at mid-period.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_clk <= 1'b0;
        end else if (en) begin
            if (w_term)
                r_clk <= 1'b1;
            else if (w_inc == w_half)
                r_clk <= 1'b0;
        end else if (div_ld) begin
            r_clk <= 1'b0;
        end
    end

    // Ring advance plus tick and wrap strobes.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_ring <= RST_RING;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_term;
            r_wrap <= w_term && (w_ring_nx == RST_RING);
            if (w_term)
                r_ring <= w_ring_nx;
        end
    end

    assign clk  = r_clk;
    assign tick = r_tick;
    assign ring = r_ring;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_frq_div_ring.sv
// Bench for frq_div_ring: one-hot and Johnson instances,
// tick events checked against a queue of expected edges.
module tb_frq_div_ring;

    logic        mclk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic        div_ld;
    logic        dir;
    logic        clk;
    logic        tick;
    logic [3:0]  ring;
    logic        wrap;

    logic        en_j;
    logic        dir_j;
    logic [15:0] div_j;
    logic        ld_j;
    logic        clk_j;
    logic        tick_j;
    logic [3:0]  ring_j;
    logic        wrap_j;

    int cyc    = 0;
    int errs   = 0;
    int checks = 0;
    int B      = 0;

    typedef struct {
        int         c;
        logic [3:0] r;
        logic       w;
    } exp_t;

    exp_t q0[$];
    exp_t qj[$];

    logic [3:0] jr [15] = '{
        4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
        4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011,
        4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000
    };

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    frq_div_ring #(
        .CNT_W(16), .RING_N(4), .JOHNSON(0), .DEF_DIV(10)
    ) u_dut (
        .mclk(mclk), .rst(rst), .en(en), .div(div),
        .div_ld(div_ld), .dir(dir), .clk(clk),
        .tick(tick), .ring(ring), .wrap(wrap)
    );

    frq_div_ring #(
        .CNT_W(16), .RING_N(4), .JOHNSON(1), .DEF_DIV(2)
    ) u_john (
        .mclk(mclk), .rst(rst), .en(en_j), .div(div_j),
        .div_ld(ld_j), .dir(dir_j), .clk(clk_j),
        .tick(tick_j), .ring(ring_j), .wrap(wrap_j)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push0(input int e, input logic [3:0] r,
                         input logic w);
        q0.push_back('{B + e, r, w});
    endtask

    task automatic at_neg(input int e);
        do @(negedge mclk); while (cyc < B + e);
    endtask

    // Monitor: every tick pops the next expected event.
    initial begin
        exp_t x;
        forever begin
            @(negedge mclk);
            while (q0.size() > 0 && q0[0].c < cyc) begin
                x = q0.pop_front();
                checks++; errs++;
                $display("FAIL tick0_missing: none, want edge %0d",
                         x.c - B);
            end
            while (qj.size() > 0 && qj[0].c < cyc) begin
                x = qj.pop_front();
                checks++; errs++;
                $display("FAIL tickj_missing: none, want edge %0d",
                         x.c - B);
            end
            if (tick === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL tick0_extra: edge %0d, want none",
                             cyc - B);
                end else begin
                    x = q0.pop_front();
                    chk("tick0_edge", cyc - B, x.c - B);
                    chk("ring0", {28'd0, ring}, {28'd0, x.r});
                    chk("wrap0", {31'd0, wrap}, {31'd0, x.w});
                end
            end else if (wrap !== 1'b0) begin
                checks++; errs++;
                $display("FAIL wrap0_alone: got %b want 0", wrap);
            end
            if (tick_j === 1'b1) begin
                if (qj.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL tickj_extra: edge %0d, want none",
                             cyc - B);
                end else begin
                    x = qj.pop_front();
                    chk("tickj_edge", cyc - B, x.c - B);
                    chk("ringj", {28'd0, ring_j}, {28'd0, x.r});
                    chk("wrapj", {31'd0, wrap_j}, {31'd0, x.w});
                end
            end
        end
    end

    // Stimulus: directed phases with hand-computed tick edges.
    initial begin
        rst = 1'b0; en = 1'b0; div = '0; div_ld = 1'b0; dir = 1'b1;
        en_j = 1'b0; dir_j = 1'b1; div_j = '0; ld_j = 1'b0;
        @(negedge mclk);
        @(negedge mclk);
        chk("rst_clk", {31'd0, clk}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_ring", {28'd0, ring}, 32'd1);
        chk("rst_ringj", {28'd0, ring_j}, 32'd0);
        chk("rst_clkj", {31'd0, clk_j}, 32'd0);

        B = cyc;
        rst = 1'b1; en = 1'b1; en_j = 1'b1;
        push0(10, 4'b0010, 1'b0);
        push0(20, 4'b0100, 1'b0);
        push0(30, 4'b1000, 1'b0);
        push0(40, 4'b0001, 1'b1);
        push0(50, 4'b0010, 1'b0);
        for (int i = 0; i < 15; i++)
            qj.push_back('{B + 2 * (i + 1), jr[i], (i == 7 || i == 13)});

        at_neg(9);  chk("clk_pre", {31'd0, clk}, 32'd0);
        at_neg(14); chk("clk_d10_hi", {31'd0, clk}, 32'd1);
        at_neg(15); chk("clk_d10_fall", {31'd0, clk}, 32'd0);
        at_neg(19); chk("clk_d10_lo", {31'd0, clk}, 32'd0);
        at_neg(20); chk("clk_d10_rise", {31'd0, clk}, 32'd1);
        at_neg(22); dir_j = 1'b0;
        at_neg(30); en_j = 1'b0;
        at_neg(40); chk("ringj_hold", {28'd0, ring_j}, 32'h8);

        at_neg(50);
        en = 1'b0; div = 16'd5; div_ld = 1'b1;
        push0(56, 4'b0100, 1'b0);
        push0(61, 4'b1000, 1'b0);
        push0(66, 4'b0001, 1'b1);
        at_neg(51);
        en = 1'b1; div_ld = 1'b0;
        chk("clk_ld_clr", {31'd0, clk}, 32'd0);
        at_neg(58); chk("clk_d5_hi", {31'd0, clk}, 32'd1);
        at_neg(59); chk("clk_d5_fall", {31'd0, clk}, 32'd0);
        at_neg(60); chk("clk_d5_lo", {31'd0, clk}, 32'd0);
        at_neg(61); chk("clk_d5_rise", {31'd0, clk}, 32'd1);

        at_neg(66);
        en = 1'b0; div = 16'd0; div_ld = 1'b1;
        push0(69, 4'b0010, 1'b0);
        push0(71, 4'b0100, 1'b0);
        push0(73, 4'b1000, 1'b0);
        push0(75, 4'b0001, 1'b1);
        at_neg(67); en = 1'b1; div_ld = 1'b0;
        at_neg(69); chk("clk_d2_a", {31'd0, clk}, 32'd1);
        at_neg(70); chk("clk_d2_b", {31'd0, clk}, 32'd0);
        at_neg(71); chk("clk_d2_c", {31'd0, clk}, 32'd1);
        at_neg(72); chk("clk_d2_d", {31'd0, clk}, 32'd0);

        at_neg(75);
        en = 1'b0; div = 16'd10; div_ld = 1'b1;
        push0(86, 4'b0010, 1'b0);
        push0(90, 4'b0100, 1'b0);
        push0(94, 4'b1000, 1'b0);
        push0(98, 4'b0001, 1'b1);
        push0(104, 4'b0010, 1'b0);
        push0(112, 4'b0100, 1'b0);
        push0(120, 4'b1000, 1'b0);
        push0(135, 4'b0001, 1'b1);
        push0(143, 4'b1000, 1'b0);
        push0(151, 4'b0100, 1'b0);
        push0(159, 4'b0010, 1'b0);
        push0(167, 4'b0001, 1'b1);
        push0(175, 4'b1000, 1'b0);
        at_neg(76);  en = 1'b1; div_ld = 1'b0;
        at_neg(79);  div = 16'd4; div_ld = 1'b1;
        at_neg(80);  div_ld = 1'b0;
        at_neg(97);  div = 16'd6; div_ld = 1'b1;
        at_neg(98);  div = 16'd3;
        at_neg(99);  div = 16'd8;
        at_neg(100); div_ld = 1'b0;
        chk("clk_d6_hi", {31'd0, clk}, 32'd1);
        at_neg(101); chk("clk_d6_fall", {31'd0, clk}, 32'd0);

        at_neg(122); en = 1'b0;
        at_neg(125);
        chk("en0_clk_hold", {31'd0, clk}, 32'd1);
        chk("en0_ring_hold", {28'd0, ring}, 32'h8);
        at_neg(129); en = 1'b1;
        at_neg(135); dir = 1'b0;

        at_neg(178);
        chk("pre_rst_clk", {31'd0, clk}, 32'd1);
        chk("pre_rst_ring", {28'd0, ring}, 32'h8);
        #2 rst = 1'b0;
        #1;
        chk("arst_clk", {31'd0, clk}, 32'd0);
        chk("arst_tick", {31'd0, tick}, 32'd0);
        chk("arst_wrap", {31'd0, wrap}, 32'd0);
        chk("arst_ring", {28'd0, ring}, 32'd1);
        chk("arst_ringj", {28'd0, ring_j}, 32'd0);
        at_neg(179);
        rst = 1'b1;
        push0(189, 4'b1000, 1'b0);

        at_neg(192);
        chk("q0_drained", q0.size(), 32'd0);
        chk("qj_drained", qj.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
